// File: rtl/asrv32_stage_ctrl.sv
// Multi-cycle stage sequencer for the asrv32 core: IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional macro ASRV32_MEM_SKIP_EN lets non-memory instructions bypass the MEMORY stage.
module asrv32_stage_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_imem_ack,
    input  logic        i_is_mem,
    input  logic        i_dmem_ack,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_fetch_en,
    output logic        o_decode_en,
    output logic        o_alu_en,
    output logic        o_mem_en,
    output logic        o_wb_en,
    output logic [2:0]  o_stage,
    output logic [31:0] o_instret,
    output logic        o_bus_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;

    localparam logic [7:0] TMO_LAST = 8'(DMEM_TIMEOUT - 1);

    // Handshake: a data access is outstanding while in MEMORY with i_is_mem high;
    // it completes on the first cycle i_dmem_ack is seen high, which beats a timeout.
    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [7:0]  tmo_cnt_q;
    logic [31:0] instret_q;
    logic        mem_wait;
    logic        tmo_hit;
    logic        flushable;
    logic        commit;

    assign mem_wait  = (state_q == S_MEMORY) && i_is_mem && !i_dmem_ack && !i_stall && !i_flush;
    assign tmo_hit   = mem_wait && (tmo_cnt_q == TMO_LAST);
    assign flushable = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                       (state_q == S_MEMORY) || (state_q == S_WRITEBACK);
    // A flush in WRITEBACK still retires the instruction.
    assign commit    = (state_q == S_WRITEBACK) && (i_flush || !i_stall);

    always_comb begin
        state_d = state_q;
        if (i_flush && flushable) begin
            state_d = S_FETCH;
        end else if (i_stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_FETCH:     if (i_imem_ack) state_d = S_DECODE;
                S_DECODE:    state_d = S_EXECUTE;
`ifdef ASRV32_MEM_SKIP_EN
                S_EXECUTE:   state_d = i_is_mem ? S_MEMORY : S_WRITEBACK;
`else
                S_EXECUTE:   state_d = S_MEMORY;
`endif
                S_MEMORY: begin
                    if (!i_is_mem || i_dmem_ack) state_d = S_WRITEBACK;
                    else if (tmo_hit)            state_d = S_FETCH;
                end
                S_WRITEBACK: state_d = i_start ? S_FETCH : S_IDLE;
                default:     state_d = i_start ? S_FETCH : S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            tmo_cnt_q <= 8'd0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            // Counter is held at zero outside MEMORY so every entry starts fresh.
            if (state_q != S_MEMORY)
                tmo_cnt_q <= 8'd0;
            else if (mem_wait)
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (commit)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign o_fetch_en  = (state_q == S_FETCH)     && !i_stall;
    assign o_decode_en = (state_q == S_DECODE)    && !i_stall;
    assign o_alu_en    = (state_q == S_EXECUTE)   && !i_stall;
    assign o_mem_en    = (state_q == S_MEMORY)    && !i_stall;
    assign o_wb_en     = (state_q == S_WRITEBACK) && !i_stall;
    assign o_stage     = state_q;
    assign o_instret   = instret_q;
    assign o_bus_err   = tmo_hit;

endmodule

// File: tb/tb_asrv32_stage_ctrl.sv
// Directed self-checking bench for asrv32_stage_ctrl (DMEM_TIMEOUT=4).
module tb_asrv32_stage_ctrl;

`ifdef ASRV32_MEM_SKIP_EN
    localparam int CYC = 4;
`else
    localparam int CYC = 5;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_imem_ack;
    logic        i_is_mem;
    logic        i_dmem_ack;
    logic        i_stall;
    logic        i_flush;
    logic        o_fetch_en;
    logic        o_decode_en;
    logic        o_alu_en;
    logic        o_mem_en;
    logic        o_wb_en;
    logic [2:0]  o_stage;
    logic [31:0] o_instret;
    logic        o_bus_err;

    int tests_run = 0;
    int failures  = 0;

    asrv32_stage_ctrl #(.DMEM_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_imem_ack(i_imem_ack),
        .i_is_mem(i_is_mem), .i_dmem_ack(i_dmem_ack), .i_stall(i_stall), .i_flush(i_flush),
        .o_fetch_en(o_fetch_en), .o_decode_en(o_decode_en), .o_alu_en(o_alu_en),
        .o_mem_en(o_mem_en), .o_wb_en(o_wb_en), .o_stage(o_stage),
        .o_instret(o_instret), .o_bus_err(o_bus_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [4:0] enables();
        return {o_fetch_en, o_decode_en, o_alu_en, o_mem_en, o_wb_en};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_start = 0; i_imem_ack = 0; i_is_mem = 0; i_dmem_ack = 0; i_stall = 0; i_flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst_n = 0;
        #2;
        i_rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst_n = 0;
        #3;
        tests_run++; if (o_stage !== 3'd0) begin failures++; $display("FAIL reset_stage got %0d exp 0", o_stage); end
        tests_run++; if (enables() !== 5'b0) begin failures++; $display("FAIL reset_en got %b exp 00000", enables()); end
        tests_run++; if (o_instret !== 32'd0) begin failures++; $display("FAIL reset_instret got %0d exp 0", o_instret); end
        tests_run++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got %b exp 0", o_bus_err); end
        @(negedge i_clk);
        i_rst_n = 1;
        step();
        tests_run++; if (o_stage !== 3'd0) begin failures++; $display("FAIL idle_hold got %0d exp 0", o_stage); end
    endtask

    task automatic test_back_to_back();
        int alu_cnt = 0;
        int bad_hot = 0;
        int drain = 0;
        do_reset();
        i_start = 1; i_imem_ack = 1; i_is_mem = 0;
        step();
        tests_run++; if (o_stage !== 3'd1) begin failures++; $display("FAIL b2b_first_fetch got %0d exp 1", o_stage); end
        for (int i = 0; i < 10 * CYC; i++) begin
            if (o_alu_en) alu_cnt++;
            if ($countones(enables()) > 1) bad_hot++;
            step();
        end
        tests_run++; if (o_instret !== 32'd10) begin failures++; $display("FAIL b2b_instret got %0d exp 10", o_instret); end
        tests_run++; if (alu_cnt !== 10) begin failures++; $display("FAIL b2b_alu_cycles got %0d exp 10", alu_cnt); end
        tests_run++; if (bad_hot !== 0) begin failures++; $display("FAIL b2b_onehot got %0d exp 0", bad_hot); end
        // Dropping i_start mid-instruction lets it finish, then parks in IDLE.
        i_start = 0;
        for (int k = 0; k < 12 && o_stage !== 3'd0; k++) begin
            step();
            drain++;
        end
        tests_run++; if (drain !== CYC) begin failures++; $display("FAIL start_fall_cycles got %0d exp %0d", drain, CYC); end
        tests_run++; if (o_instret !== 32'd11) begin failures++; $display("FAIL start_fall_instret got %0d exp 11", o_instret); end
    endtask

    task automatic test_load();
        int mem_cnt = 0;
        int err_cnt = 0;
        do_reset();
        i_start = 1; i_imem_ack = 1; i_is_mem = 1;
        step();
        i_start = 0;
        step(); step(); step();
        tests_run++; if (o_stage !== 3'd4) begin failures++; $display("FAIL load_mem_entry got %0d exp 4", o_stage); end
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) i_dmem_ack = 1;
            #1;
            if (o_mem_en) mem_cnt++;
            if (o_bus_err) err_cnt++;
            step();
        end
        i_dmem_ack = 0;
        tests_run++; if (mem_cnt !== 3) begin failures++; $display("FAIL load_mem_cycles got %0d exp 3", mem_cnt); end
        tests_run++; if (o_wb_en !== 1'b1) begin failures++; $display("FAIL load_wb_en got %b exp 1", o_wb_en); end
        step();
        tests_run++; if (o_instret !== 32'd1) begin failures++; $display("FAIL load_instret got %0d exp 1", o_instret); end
        tests_run++; if (err_cnt !== 0) begin failures++; $display("FAIL load_bus_err got %0d exp 0", err_cnt); end
        tests_run++; if (o_stage !== 3'd0) begin failures++; $display("FAIL load_idle got %0d exp 0", o_stage); end
    endtask

    task automatic test_timeout();
        do_reset();
        i_start = 1; i_imem_ack = 1; i_is_mem = 1;
        step();
        i_start = 0;
        step(); step(); step();
        for (int c = 1; c <= 3; c++) begin
            tests_run++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL tmo_early_err cycle %0d got %b exp 0", c, o_bus_err); end
            step();
        end
        tests_run++; if (o_bus_err !== 1'b1) begin failures++; $display("FAIL tmo_err_pulse got %b exp 1", o_bus_err); end
        tests_run++; if (o_stage !== 3'd4) begin failures++; $display("FAIL tmo_in_mem got %0d exp 4", o_stage); end
        i_imem_ack = 0;
        step();
        tests_run++; if (o_stage !== 3'd1) begin failures++; $display("FAIL tmo_to_fetch got %0d exp 1", o_stage); end
        tests_run++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL tmo_err_one_cycle got %b exp 0", o_bus_err); end
        tests_run++; if (o_instret !== 32'd0) begin failures++; $display("FAIL tmo_instret got %0d exp 0", o_instret); end
        // Same store, ack arriving on the cycle that would otherwise time out.
        i_imem_ack = 1;
        step(); step(); step();
        step(); step(); step();
        i_dmem_ack = 1;
        #1;
        tests_run++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL ack_vs_tmo_err got %b exp 0", o_bus_err); end
        step();
        i_dmem_ack = 0;
        tests_run++; if (o_stage !== 3'd5) begin failures++; $display("FAIL ack_vs_tmo_wb got %0d exp 5", o_stage); end
        step();
        tests_run++; if (o_instret !== 32'd1) begin failures++; $display("FAIL ack_vs_tmo_instret got %0d exp 1", o_instret); end
    endtask

    task automatic test_stall_flush();
        int alu_cnt = 0;
        do_reset();
        i_start = 1; i_imem_ack = 1; i_is_mem = 0;
        step(); step(); step();
        i_stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++; if (enables() !== 5'b0) begin failures++; $display("FAIL stall_en cycle %0d got %b exp 00000", c, enables()); end
            tests_run++; if (o_stage !== 3'd3) begin failures++; $display("FAIL stall_hold cycle %0d got %0d exp 3", c, o_stage); end
            step();
        end
        i_stall = 0;
        i_start = 0;
        for (int k = 0; k < 10 && o_stage !== 3'd0; k++) begin
            #1;
            if (o_alu_en) alu_cnt++;
            step();
        end
        tests_run++; if (alu_cnt !== 1) begin failures++; $display("FAIL stall_alu_once got %0d exp 1", alu_cnt); end
        tests_run++; if (o_instret !== 32'd1) begin failures++; $display("FAIL stall_instret got %0d exp 1", o_instret); end
        i_start = 1;
        step(); step();
        i_start = 0;
        i_stall = 1; i_flush = 1;
        step();
        tests_run++; if (o_stage !== 3'd1) begin failures++; $display("FAIL flush_over_stall got %0d exp 1", o_stage); end
        tests_run++; if (o_instret !== 32'd1) begin failures++; $display("FAIL flush_instret got %0d exp 1", o_instret); end
        i_stall = 0; i_flush = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        tests_run++; if (o_instret !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got %h exp ffffffff", o_instret); end
        i_start = 1; i_imem_ack = 1; i_is_mem = 0;
        step();
        i_start = 0;
        for (int k = 0; k < 10 && o_stage !== 3'd0; k++) step();
        tests_run++; if (o_instret !== 32'd0) begin failures++; $display("FAIL wrap_instret got %h exp 00000000", o_instret); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_start = 1; i_imem_ack = 1; i_is_mem = 0;
        for (int k = 0; k < 10 && o_instret !== 32'd1; k++) step();
        i_is_mem = 1;
        step(); step(); step();
        tests_run++; if (o_stage !== 3'd4) begin failures++; $display("FAIL arst_pre_mem got %0d exp 4", o_stage); end
        tests_run++; if (o_instret !== 32'd1) begin failures++; $display("FAIL arst_pre_instret got %0d exp 1", o_instret); end
        #2;
        i_rst_n = 0;
        #1;
        tests_run++; if (o_stage !== 3'd0) begin failures++; $display("FAIL arst_stage got %0d exp 0", o_stage); end
        tests_run++; if (enables() !== 5'b0) begin failures++; $display("FAIL arst_en got %b exp 00000", enables()); end
        tests_run++; if (o_instret !== 32'd0) begin failures++; $display("FAIL arst_instret got %0d exp 0", o_instret); end
        tests_run++; if (o_bus_err !== 1'b0) begin failures++; $display("FAIL arst_bus_err got %b exp 0", o_bus_err); end
        clear_inputs();
        #1;
        i_rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        i_rst_n = 0;
        test_reset();
        test_back_to_back();
        test_load();
        test_timeout();
        test_stall_flush();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
